// File: rtl/pwm_oc_deadtime_monitor_pkg.sv
// Shared definitions for the PWM output-compare dead-time monitor.
//   dt_state_t : monitor FSM states (3-bit encoding)
//   EDGE_RISE  : edge tag for a gap that preceded high-side turn-on
//   EDGE_FALL  : edge tag for a gap that preceded low-side turn-on
package pwm_oc_deadtime_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_GAP_R = 3'd3,
        ST_GAP_F = 3'd4,
        ST_FAULT = 3'd5
    } dt_state_t;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

endpackage

// File: rtl/pwm_dt_gap_counter.sv
// Saturating dead-time gap counter.
//   clk_psc_i  : prescaled timer clock
//   rst_n_i    : asynchronous active-low reset
//   clr_i      : clear the count to 0 (highest priority)
//   load_one_i : load 1 (first gap cycle seen)
//   inc_i      : increment, holding at all-ones
//   cnt_o      : current count
module pwm_dt_gap_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_psc_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_one_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (load_one_i) begin
            cnt_o <= WIDTH'(1);
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_oc_deadtime_monitor.sv
// Dead-time monitor for a complementary PWM pair.
// Measures each gap (both gates low) in clk_psc cycles, reports it with an
// edge tag, flags gaps shorter than the shadowed minimum and shoot-through.
//   clk_psc_i        : prescaled timer clock
//   rst_n_i          : asynchronous active-low reset
//   pwm_high_i       : high-side gate under observation
//   pwm_low_i        : low-side gate under observation
//   update_event_i   : loads dt_min_preload_i into the active minimum
//   dt_min_preload_i : minimum allowed dead time (preload)
//   clr_flags_i      : one-cycle clear of the sticky flags
//   dt_value_o       : last measured gap length
//   dt_edge_o        : 1 = gap before high-side turn-on, 0 = before low-side
//   dt_valid_o       : one-cycle strobe on each report
//   dt_viol_o        : sticky, a gap was below the active minimum
//   shoot_through_o  : sticky, both gates seen high
//   fault_o          : dt_viol_o | shoot_through_o
module pwm_oc_deadtime_monitor
    import pwm_oc_deadtime_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_psc_i,
    input  logic             rst_n_i,
    input  logic             pwm_high_i,
    input  logic             pwm_low_i,
    input  logic             update_event_i,
    input  logic [WIDTH-1:0] dt_min_preload_i,
    input  logic             clr_flags_i,
    output logic [WIDTH-1:0] dt_value_o,
    output logic             dt_edge_o,
    output logic             dt_valid_o,
    output logic             dt_viol_o,
    output logic             shoot_through_o,
    output logic             fault_o
);

    dt_state_t        state;
    logic [WIDTH-1:0] dt_min_act;
    logic [WIDTH-1:0] gap_cnt;
    logic             cnt_clr;
    logic             cnt_load_one;
    logic             cnt_inc;
    logic             both_low;
    logic             both_high;

    assign both_low  = !pwm_high_i && !pwm_low_i;
    assign both_high = pwm_high_i && pwm_low_i;

    // Counter controls follow the same sample the FSM acts on, so the count
    // seen at report time already includes every gap cycle.
    always_comb begin
        cnt_clr      = 1'b0;
        cnt_load_one = 1'b0;
        cnt_inc      = 1'b0;
        if (both_high) begin
            cnt_clr = 1'b1;
        end else if (both_low) begin
            cnt_load_one = (state == ST_LOW)   || (state == ST_HIGH);
            cnt_inc      = (state == ST_GAP_R) || (state == ST_GAP_F);
        end
    end

    pwm_dt_gap_counter #(
        .WIDTH(WIDTH)
    ) u_gap_counter (
        .clk_psc_i (clk_psc_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (cnt_clr),
        .load_one_i(cnt_load_one),
        .inc_i     (cnt_inc),
        .cnt_o     (gap_cnt)
    );

    // Shadow register: a compare in the update cycle still sees the old value.
    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dt_min_act <= '0;
        end else if (update_event_i) begin
            dt_min_act <= dt_min_preload_i;
        end
    end

    // FSM with registered report outputs. Sticky clears are written first so
    // a set later in the same block takes precedence.
    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= ST_IDLE;
            dt_value_o      <= '0;
            dt_edge_o       <= 1'b0;
            dt_valid_o      <= 1'b0;
            dt_viol_o       <= 1'b0;
            shoot_through_o <= 1'b0;
        end else begin
            dt_valid_o <= 1'b0;
            if (clr_flags_i) begin
                dt_viol_o       <= 1'b0;
                shoot_through_o <= 1'b0;
            end

            if (both_high) begin
                state           <= ST_FAULT;
                shoot_through_o <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (pwm_high_i)     state <= ST_HIGH;
                        else if (pwm_low_i) state <= ST_LOW;
                    end
                    ST_LOW: begin
                        if (both_low) begin
                            state <= ST_GAP_R;
                        end else if (pwm_high_i) begin
                            state      <= ST_HIGH;
                            dt_valid_o <= 1'b1;
                            dt_value_o <= '0;
                            dt_edge_o  <= EDGE_RISE;
                            if (dt_min_act != '0) dt_viol_o <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (both_low) begin
                            state <= ST_GAP_F;
                        end else if (pwm_low_i) begin
                            state      <= ST_LOW;
                            dt_valid_o <= 1'b1;
                            dt_value_o <= '0;
                            dt_edge_o  <= EDGE_FALL;
                            if (dt_min_act != '0) dt_viol_o <= 1'b1;
                        end
                    end
                    ST_GAP_R: begin
                        if (pwm_high_i) begin
                            state      <= ST_HIGH;
                            dt_valid_o <= 1'b1;
                            dt_value_o <= gap_cnt;
                            dt_edge_o  <= EDGE_RISE;
                            if (gap_cnt < dt_min_act) dt_viol_o <= 1'b1;
                        end else if (pwm_low_i) begin
                            state <= ST_LOW;
                        end
                    end
                    ST_GAP_F: begin
                        if (pwm_low_i) begin
                            state      <= ST_LOW;
                            dt_valid_o <= 1'b1;
                            dt_value_o <= gap_cnt;
                            dt_edge_o  <= EDGE_FALL;
                            if (gap_cnt < dt_min_act) dt_viol_o <= 1'b1;
                        end else if (pwm_high_i) begin
                            state <= ST_HIGH;
                        end
                    end
                    ST_FAULT: begin
                        if (both_low) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign fault_o = dt_viol_o | shoot_through_o;

endmodule

// File: tb/tb_pwm_oc_deadtime_monitor.sv
module tb_pwm_oc_deadtime_monitor;

    localparam int unsigned WIDTH = 8;

    logic             clk_psc_i;
    logic             rst_n_i;
    logic             pwm_high_i;
    logic             pwm_low_i;
    logic             update_event_i;
    logic [WIDTH-1:0] dt_min_preload_i;
    logic             clr_flags_i;
    logic [WIDTH-1:0] dt_value_o;
    logic             dt_edge_o;
    logic             dt_valid_o;
    logic             dt_viol_o;
    logic             shoot_through_o;
    logic             fault_o;

    int n_cmp;
    int n_bad;

    pwm_oc_deadtime_monitor #(
        .WIDTH(WIDTH)
    ) dut (
        .clk_psc_i       (clk_psc_i),
        .rst_n_i         (rst_n_i),
        .pwm_high_i      (pwm_high_i),
        .pwm_low_i       (pwm_low_i),
        .update_event_i  (update_event_i),
        .dt_min_preload_i(dt_min_preload_i),
        .clr_flags_i     (clr_flags_i),
        .dt_value_o      (dt_value_o),
        .dt_edge_o       (dt_edge_o),
        .dt_valid_o      (dt_valid_o),
        .dt_viol_o       (dt_viol_o),
        .shoot_through_o (shoot_through_o),
        .fault_o         (fault_o)
    );

    initial clk_psc_i = 1'b0;
    always #5 clk_psc_i = ~clk_psc_i;

    typedef struct {
        logic             hi;
        logic             lo;
        logic             upd;
        logic [WIDTH-1:0] pre;
        logic             clr;
        logic             e_valid;
        logic [WIDTH-1:0] e_value;
        logic             e_edge;
        logic             e_viol;
        logic             e_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic hi, input logic lo, input logic upd,
                       input int pre, input logic clr,
                       input logic v, input int val, input logic edg,
                       input logic viol, input logic st);
        vec_t t;
        t.hi = hi; t.lo = lo; t.upd = upd; t.pre = WIDTH'(pre); t.clr = clr;
        t.e_valid = v; t.e_value = WIDTH'(val); t.e_edge = edg;
        t.e_viol = viol; t.e_st = st;
        vecs.push_back(t);
    endtask

    task automatic add_n(input int n, input logic hi, input logic lo,
                         input logic v, input int val, input logic edg,
                         input logic viol, input logic st);
        for (int i = 0; i < n; i++) add(hi, lo, 1'b0, 0, 1'b0, v, val, edg, viol, st);
    endtask

    task automatic check_all(input string name, input logic v, input int val,
                             input logic edg, input logic viol, input logic st);
        logic [WIDTH+4:0] got;
        logic [WIDTH+4:0] exp;
        got = {dt_valid_o, dt_value_o, dt_edge_o, dt_viol_o, shoot_through_o, fault_o};
        exp = {v, WIDTH'(val), edg, viol, st, viol | st};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b value=%0d edge=%0b viol=%0b st=%0b fault=%0b, expected valid=%0b value=%0d edge=%0b viol=%0b st=%0b fault=%0b",
                     name, dt_valid_o, dt_value_o, dt_edge_o, dt_viol_o, shoot_through_o, fault_o,
                     v, val, edg, viol, st, viol | st);
        end
    endtask

    task automatic drive(input logic hi, input logic lo, input logic upd,
                         input int pre, input logic clr);
        pwm_high_i       = hi;
        pwm_low_i        = lo;
        update_event_i   = upd;
        dt_min_preload_i = WIDTH'(pre);
        clr_flags_i      = clr;
        @(posedge clk_psc_i);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // ---- stimulus table: inputs, then expected outputs after the edge ----
        //  hi lo upd pre clr | valid value edge viol st
        add  (0,1,0,0,0, 0,0,0,0,0);          // first edge from IDLE: unmeasured
        add_n(3, 0,0, 0,0,0,0,0);             // 3-cycle gap
        add  (1,0,0,0,0, 1,3,1,0,0);          // rising report dt=3
        add  (1,0,0,0,0, 0,3,1,0,0);
        add_n(3, 0,0, 0,3,1,0,0);
        add  (0,1,0,0,0, 1,3,0,0,0);          // falling report dt=3
        add  (0,1,1,5,0, 0,3,0,0,0);          // min := 5
        add_n(3, 0,0, 0,3,0,0,0);
        add  (1,0,0,0,0, 1,3,1,1,0);          // 3 < 5: violation
        add  (1,0,0,0,1, 0,3,1,0,0);          // clear flags
        add_n(5, 0,0, 0,3,1,0,0);
        add  (0,1,0,0,0, 1,5,0,0,0);          // 5 == 5: legal
        add  (0,1,0,2,0, 0,5,0,0,0);          // preload 2, no update
        add_n(4, 0,0, 0,5,0,0,0);
        add  (1,0,0,2,0, 1,4,1,1,0);          // 4 < 5 (old min still active)
        add  (1,0,1,2,1, 0,4,1,0,0);          // update to 2, clear
        add_n(4, 0,0, 0,4,1,0,0);
        add  (0,1,0,0,0, 1,4,0,0,0);          // 4 >= 2
        add  (0,1,1,0,0, 0,4,0,0,0);          // min := 0
        add  (1,0,0,0,0, 1,0,1,0,0);          // bypass swap, legal at min 0
        add  (1,0,1,2,0, 0,0,1,0,0);          // min := 2
        add  (0,1,0,0,0, 1,0,0,1,0);          // bypass swap, 0 < 2
        add  (0,1,0,0,1, 0,0,0,0,0);
        add_n(2, 0,0, 0,0,0,0,0);
        add  (1,0,1,3,0, 1,2,1,0,0);          // same-cycle update: old min 2 used
        add  (1,0,0,0,0, 0,2,1,0,0);
        add  (1,1,0,0,0, 0,2,1,0,1);          // shoot-through
        add  (1,1,0,0,0, 0,2,1,0,1);
        add  (0,0,0,0,0, 0,2,1,0,1);          // -> IDLE, gap not measured
        add  (0,1,0,0,0, 0,2,1,0,1);          // first edge after FAULT: unmeasured
        add  (1,0,0,0,0, 1,0,1,1,1);          // swap, 0 < 3
        add  (1,0,0,0,1, 0,0,1,0,0);
        add  (1,1,0,0,1, 0,0,1,0,1);          // clear vs set: set wins
        add  (0,0,0,0,0, 0,0,1,0,1);
        add  (1,1,0,0,1, 0,0,1,0,1);          // shoot-through from IDLE, set wins
        add  (0,0,0,0,0, 0,0,1,0,1);
        add  (1,0,0,0,1, 0,0,1,0,0);          // unmeasured edge, flags cleared

        // ---- reset with random inputs ----
        rst_n_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pwm_high_i       = 1'($urandom);
            pwm_low_i        = 1'($urandom);
            update_event_i   = 1'($urandom);
            dt_min_preload_i = WIDTH'($urandom);
            clr_flags_i      = 1'($urandom);
            @(posedge clk_psc_i);
            #1;
        end
        check_all("reset_hold", 0, 0, 0, 0, 0);
        pwm_high_i = 0; pwm_low_i = 0; update_event_i = 0;
        dt_min_preload_i = '0; clr_flags_i = 0;
        rst_n_i = 1'b1;
        @(posedge clk_psc_i);
        #1;
        check_all("reset_release", 0, 0, 0, 0, 0);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].hi, vecs[i].lo, vecs[i].upd, int'(vecs[i].pre), vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, int'(vecs[i].e_value),
                      vecs[i].e_edge, vecs[i].e_viol, vecs[i].e_st);
        end

        // ---- saturation: 300-cycle falling gap (state HIGH, min 3) ----
        for (int i = 0; i < 300; i++) drive(0, 0, 0, 0, 0);
        check_all("sat_gap_no_report", 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        check_all("sat_report", 1, 255, 0, 0, 0);

        // ---- mid-operation async reset ----
        drive(1, 1, 0, 0, 0);
        check_all("pre_rst_st", 0, 255, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);                 // mid-gap
        #2 rst_n_i = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0);
        @(posedge clk_psc_i);
        #1 rst_n_i = 1'b1;
        drive(1, 0, 0, 0, 0);
        check_all("post_rst_first_edge", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check_all("post_rst_gap", 1, 2, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
